// File: rtl/bcd_addsub_seq_if.sv
// Request/response bundle for bcd_addsub_seq.
// master: the requester (drives operands/start); slave: the BCD unit.
interface bcd_addsub_seq_if;
  logic       start;
  logic       op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] result;
  logic       carry;
  logic       neg;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output start, op, a, b,
                  input  result, carry, neg, busy, done, err);
  modport slave  (input  start, op, a, b,
                  output result, carry, neg, busy, done, err);
endinterface

// File: rtl/bcd_addsub_seq.sv
// Two-digit packed-BCD add/subtract, one digit per cycle.
// Subtract is a + 9's-complement(b) + 1; a missing tens carry means a<b and
// the raw value is turned into its 100's complement in NEGFIX.
// Optional macro BCD_INPUT_CHECK_EN: reject non-BCD operand digits at start
// (err=1, straight to DONE). Without it err is tied low.
module bcd_addsub_seq (
  input  logic              clk,
  input  logic              rst,
  bcd_addsub_seq_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, UNITS, TENS, NEGFIX, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic       op_q, op_d;
  logic [3:0] ud_q, ud_d;       // units digit of raw value
  logic [3:0] td_q, td_d;       // tens digit of raw value (NEGFIX input)
  logic       uc_q, uc_d;       // digit carry units -> tens
  logic [7:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       neg_q, neg_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] bx;
  logic [4:0] u_sum, t_sum, f_u;
  logic [3:0] f_t;

  // one decimal digit add with adjust: {digit carry, digit}
  function automatic logic [4:0] dig_add(input logic [3:0] x, input logic [3:0] y,
                                         input logic cin);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'd0, cin};
    if (s > 5'd9) dig_add = {1'b1, s[3:0] + 4'd6};
    else          dig_add = s;
  endfunction

  function automatic logic [3:0] nines(input logic [3:0] d);
    nines = 4'd9 - d;
  endfunction

`ifdef BCD_INPUT_CHECK_EN
  logic err_q, err_d;
  logic bad_in;
  // any operand digit outside 0..9 at the moment of acceptance
  always_comb begin
    bad_in = (bus.a[7:4] > 4'd9) || (bus.a[3:0] > 4'd9) ||
             (bus.b[7:4] > 4'd9) || (bus.b[3:0] > 4'd9);
  end
`endif

  // shared digit-serial datapath: units, tens, and the 100-R correction
  always_comb begin
    bx    = op_q ? {nines(b_q[7:4]), nines(b_q[3:0])} : b_q;
    u_sum = dig_add(a_q[3:0], bx[3:0], op_q);
    t_sum = dig_add(a_q[7:4], bx[7:4], uc_q);
    f_u   = dig_add(nines(ud_q), 4'd0, 1'b1);
    f_t   = 4'(dig_add(nines(td_q), 4'd0, f_u[4]));
  end

  // next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    ud_d     = ud_q;
    td_d     = td_q;
    uc_d     = uc_q;
    result_d = result_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
`ifdef BCD_INPUT_CHECK_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        // the cycle with done high is not an accepting cycle
        if (bus.start && !done_q) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          state_d = UNITS;
`ifdef BCD_INPUT_CHECK_EN
          err_d   = 1'b0;
          if (bad_in) begin
            err_d    = 1'b1;
            result_d = 8'h00;
            carry_d  = 1'b0;
            neg_d    = 1'b0;
            state_d  = DONE;
          end
`endif
        end
      end
      UNITS: begin
        {uc_d, ud_d} = u_sum;
        state_d      = TENS;
      end
      TENS: begin
        if (!op_q) begin
          result_d = {t_sum[3:0], ud_q};
          carry_d  = t_sum[4];
          neg_d    = 1'b0;
          state_d  = DONE;
        end else if (t_sum[4]) begin
          result_d = {t_sum[3:0], ud_q};
          carry_d  = 1'b0;
          neg_d    = 1'b0;
          state_d  = DONE;
        end else begin
          td_d    = t_sum[3:0];
          state_d = NEGFIX;
        end
      end
      NEGFIX: begin
        result_d = {f_t, f_u[3:0]};
        carry_d  = 1'b0;
        neg_d    = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // operand, digit and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 1'b0;
      ud_q     <= 4'd0;
      td_q     <= 4'd0;
      uc_q     <= 1'b0;
      result_q <= 8'h00;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      ud_q     <= ud_d;
      td_q     <= td_d;
      uc_q     <= uc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef BCD_INPUT_CHECK_EN
  // error flag register
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.neg    = neg_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
